// File: rtl/master_pin_ctrl_pkg.sv
// Shared types and helpers for the master-PIN change sequencer.
// PIN packets carry a one-cycle status strobe plus four 4-bit digits.
package master_pin_ctrl_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  localparam pinPac_t PIN_ZERO = 17'h0_0000;

  localparam logic [1:0] ERR_AUTH    = 2'd0;
  localparam logic [1:0] ERR_CONFIRM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LOCKED  = 2'd3;

  // Exact digit equality; status and digit range are deliberately ignored.
  function automatic logic pin_digits_eq(input pinPac_t a, input pinPac_t b);
    return (a.digit1 == b.digit1) && (a.digit2 == b.digit2) &&
           (a.digit3 == b.digit3) && (a.digit4 == b.digit4);
  endfunction

  function automatic pinPac_t pin_with_status(input pinPac_t p, input logic st);
    pinPac_t r;
    r        = p;
    r.status = st;
    return r;
  endfunction

endpackage

// File: rtl/master_pin_ctrl_cycle_timer.sv
// Down-counter: load a value, decrement on request, o_zero while the count is 0.
// Used for the PIN-entry timeout and the lockout window.
module master_pin_ctrl_cycle_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/master_pin_ctrl.sv
// Master-PIN change sequencer: authenticate, capture and confirm a new PIN, then
// drive the update block's enable/strobe handshake. Optional lockout: `define LOCKOUT_EN.
module master_pin_ctrl
  import master_pin_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  pinPac_t    i_pin_in,
  input  pinPac_t    i_cur_master,
  output logic       o_master_en,
  output pinPac_t    o_master_pin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_locked
);

  typedef enum logic [2:0] {
    S_IDLE, S_AUTH, S_NEW1, S_NEW2, S_COMMIT_EN, S_COMMIT_STB, S_COMMIT_REL
  } state_t;

  state_t  r_state;
  pinPac_t r_new_pin;

  logic w_strobe, w_in_entry, w_start, w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic w_auth_fail, w_locked;

  // Entry-timer control and event decode from current state and inputs.
  always_comb begin
    w_strobe    = i_pin_in.status;
    w_in_entry  = (r_state == S_AUTH) || (r_state == S_NEW1) || (r_state == S_NEW2);
    w_start     = (r_state == S_IDLE) && i_req && !w_locked;
    w_tmr_load  = w_start || (w_in_entry && w_strobe);
    w_tmr_dec   = w_in_entry && !w_strobe;
    w_auth_fail = (r_state == S_AUTH) && w_strobe && !pin_digits_eq(i_pin_in, i_cur_master);
  end

  master_pin_ctrl_cycle_timer #(.W(32)) u_entry_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (32'(TIMEOUT_CYCLES - 1)),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

`ifdef LOCKOUT_EN
  logic       r_locked;
  logic [7:0] r_fail_cnt;
  logic       w_auth_ok, w_lock_trip, w_lock_zero;

  assign w_auth_ok   = (r_state == S_AUTH) && w_strobe && pin_digits_eq(i_pin_in, i_cur_master);
  assign w_lock_trip = w_auth_fail && ((r_fail_cnt + 8'd1) >= 8'(MAX_FAILS));

  master_pin_ctrl_cycle_timer #(.W(32)) u_lock_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lock_trip),
    .i_load_val (32'(LOCK_CYCLES - 1)),
    .i_dec      (r_locked),
    .o_zero     (w_lock_zero)
  );

  // Consecutive-failure count and lockout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_cnt <= 8'd0;
      r_locked   <= 1'b0;
    end else if (r_locked && w_lock_zero) begin
      r_fail_cnt <= 8'd0;
      r_locked   <= 1'b0;
    end else if (w_auth_fail) begin
      r_fail_cnt <= (r_fail_cnt == 8'hFF) ? r_fail_cnt : r_fail_cnt + 8'd1;
      r_locked   <= r_locked | w_lock_trip;
    end else if (w_auth_ok) begin
      r_fail_cnt <= 8'd0;
      r_locked   <= r_locked;
    end else begin
      r_fail_cnt <= r_fail_cnt;
      r_locked   <= r_locked;
    end
  end

  assign w_locked = r_locked;
  assign o_locked = r_locked;
`else
  assign w_locked = 1'b0;
  assign o_locked = 1'b0;
`endif

  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(MAX_FAILS), 32'(LOCK_CYCLES), i_cur_master.status};

  // Sequencer; outputs are registered alongside each state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_new_pin    <= PIN_ZERO;
      o_master_en  <= 1'b0;
      o_master_pin <= PIN_ZERO;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= 2'd0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_master_pin <= PIN_ZERO;
          if (i_req && w_locked) begin
            o_err      <= 1'b1;
            o_err_code <= ERR_LOCKED;
          end else if (i_req) begin
            r_state <= S_AUTH;
            o_busy  <= 1'b1;
          end
        end
        S_AUTH: begin
          if (w_strobe && !w_auth_fail) begin
            r_state <= S_NEW1;
          end else if (w_strobe) begin
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= ERR_AUTH;
          end else if (w_tmr_zero) begin
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
          end
        end
        S_NEW1: begin
          if (w_strobe) begin
            r_new_pin <= pin_with_status(i_pin_in, 1'b0);
            r_state   <= S_NEW2;
          end else if (w_tmr_zero) begin
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
          end
        end
        S_NEW2: begin
          if (w_strobe && pin_digits_eq(i_pin_in, r_new_pin)) begin
            r_state      <= S_COMMIT_EN;
            o_master_en  <= 1'b1;
            o_master_pin <= pin_with_status(r_new_pin, 1'b0);
          end else if (w_strobe || w_tmr_zero) begin
            r_state    <= S_IDLE;
            r_new_pin  <= PIN_ZERO;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= w_strobe ? ERR_CONFIRM : ERR_TIMEOUT;
          end
        end
        S_COMMIT_EN: begin
          r_state             <= S_COMMIT_STB;
          o_master_pin.status <= 1'b1;
        end
        S_COMMIT_STB: begin
          r_state             <= S_COMMIT_REL;
          o_master_en         <= 1'b0;
          o_master_pin.status <= 1'b0;
          o_done              <= 1'b1;
        end
        S_COMMIT_REL: begin
          r_state   <= S_IDLE;
          r_new_pin <= PIN_ZERO;
          o_busy    <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_new_pin    <= PIN_ZERO;
          o_master_en  <= 1'b0;
          o_master_pin <= PIN_ZERO;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_pin_ctrl.sv
// Directed bench for master_pin_ctrl (TIMEOUT_CYCLES=20, MAX_FAILS=2, LOCK_CYCLES=50).
// Lockout scenario expectations follow LOCKOUT_EN.
module tb_master_pin_ctrl;
  import master_pin_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, req;
  pinPac_t    pin_in, cur_master, master_pin;
  logic       master_en, busy, done, err, locked;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;

  master_pin_ctrl #(.TIMEOUT_CYCLES(20), .MAX_FAILS(2), .LOCK_CYCLES(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .i_pin_in     (pin_in),
    .i_cur_master (cur_master),
    .o_master_en  (master_en),
    .o_master_pin (master_pin),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_err_code   (err_code),
    .o_locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic pinPac_t pk(input logic st, input logic [15:0] d);
    pinPac_t p;
    p = {st, d};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d);
    pin_in = pk(1'b1, d);
    tick();
    pin_in = pk(1'b0, 16'h0000);
  endtask

  task automatic request();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Called right after the confirming strobe has been clocked in.
  task automatic commit_check(input string t, input logic [15:0] d);
    check({t, ".en_c1"},   32'(master_en),  32'd1);
    check({t, ".pin_c1"},  32'(master_pin), 32'(pk(1'b0, d)));
    check({t, ".done_c1"}, 32'(done),       32'd0);
    tick();
    check({t, ".en_c2"},   32'(master_en),  32'd1);
    check({t, ".pin_c2"},  32'(master_pin), 32'(pk(1'b1, d)));
    tick();
    check({t, ".en_c3"},   32'(master_en),  32'd0);
    check({t, ".stb_c3"},  32'(master_pin.status), 32'd0);
    check({t, ".done_c3"}, 32'(done),       32'd1);
    tick();
    check({t, ".done_c4"}, 32'(done),       32'd0);
    check({t, ".busy_c4"}, 32'(busy),       32'd0);
    check({t, ".en_c4"},   32'(master_en),  32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req        = 1'b0;
    pin_in     = pk(1'b0, 16'h0000);
    cur_master = pk(1'b0, 16'h1234);
    repeat (3) tick();
    check("rst.en",   32'(master_en),  32'd0);
    check("rst.pin",  32'(master_pin), 32'd0);
    check("rst.busy", 32'(busy),       32'd0);
    check("rst.done", 32'(done),       32'd0);
    check("rst.err",  32'(err),        32'd0);
    check("rst.lock", 32'(locked),     32'd0);
    rst = 1'b0;
    tick();

    // Normal change 1234 -> 5678
    request();
    check("t1.busy", 32'(busy), 32'd1);
    strobe(16'h1234);
    strobe(16'h5678);
    check("t1.en_pre", 32'(master_en), 32'd0);
    strobe(16'h5678);
    commit_check("t1", 16'h5678);

    // Wrong current PIN
    request();
    strobe(16'h9999);
    check("t2.err",  32'(err),       32'd1);
    check("t2.code", 32'(err_code),  32'd0);
    check("t2.busy", 32'(busy),      32'd0);
    check("t2.en",   32'(master_en), 32'd0);
    tick();
    check("t2.err_clr", 32'(err), 32'd0);

    // Confirm mismatch, then a clean change using digits above 9
    request();
    strobe(16'h1234);
    strobe(16'h5678);
    strobe(16'h5679);
    check("t3.err",  32'(err),      32'd1);
    check("t3.code", 32'(err_code), 32'd1);
    check("t3.busy", 32'(busy),     32'd0);
    request();
    strobe(16'h1234);
    strobe(16'hABCD);
    strobe(16'hABCD);
    commit_check("t3b", 16'hABCD);

    // Strobe while idle is ignored
    strobe(16'h1234);
    check("t4.busy", 32'(busy), 32'd0);
    check("t4.err",  32'(err),  32'd0);

    // Timeout in NEW1 after 20 idle cycles
    request();
    strobe(16'h1234);
    repeat (19) tick();
    check("t5.err_pre",  32'(err),  32'd0);
    check("t5.busy_pre", 32'(busy), 32'd1);
    tick();
    check("t5.err",  32'(err),      32'd1);
    check("t5.code", 32'(err_code), 32'd2);
    check("t5.busy", 32'(busy),     32'd0);

    // Strobe on the exact expiry cycle is accepted
    request();
    strobe(16'h1234);
    repeat (19) tick();
    strobe(16'h5678);
    check("t6.err",  32'(err),  32'd0);
    check("t6.busy", 32'(busy), 32'd1);
    strobe(16'h5678);
    commit_check("t6", 16'h5678);

    // Two bad authentications
    request();
    strobe(16'h0000);
    request();
    strobe(16'h1111);
    check("t7.err", 32'(err), 32'd1);
`ifdef LOCKOUT_EN
    check("t7.locked", 32'(locked), 32'd1);
    request();
    check("t7.err3",  32'(err),      32'd1);
    check("t7.code3", 32'(err_code), 32'd3);
    check("t7.busy3", 32'(busy),     32'd0);
    repeat (46) tick();
    check("t7.still_locked", 32'(locked), 32'd1);
    repeat (4) tick();
    check("t7.unlocked", 32'(locked), 32'd0);
`else
    check("t7.locked", 32'(locked), 32'd0);
`endif
    request();
    check("t7.req_ok", 32'(busy), 32'd1);
    check("t7.no_err", 32'(err),  32'd0);
    strobe(16'h9999);
    check("t7.exit", 32'(busy), 32'd0);

    // Reset during the commit strobe cycle
    request();
    strobe(16'h1234);
    strobe(16'h5555);
    strobe(16'h5555);
    tick();
    check("t8.stb", 32'(master_pin), 32'(pk(1'b1, 16'h5555)));
    rst = 1'b1;
    #1;
    check("t8.en",   32'(master_en),  32'd0);
    check("t8.pin",  32'(master_pin), 32'd0);
    check("t8.busy", 32'(busy),       32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t8.no_done", 32'(done), 32'd0);
    end
    check("t8.idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
